jk_bank_driver: RTL

//  Drive side for a bank of WIDTH external JK flip-flops. It converts a requested next-state

---
 rtl/jk_bank_driver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/jk_bank_driver.sv
// Drive side for a bank of external JK flops: turns a target word into one
// cycle of J/K excitation, then checks the bank's Q feedback against it.
module jk_bank_driver #(
    parameter int                 WIDTH     = 4,
    parameter int                 DC_POLICY = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic             accept;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tgt_valid) state_d = DRIVE;
            DRIVE:   state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted, not just when busy.
    always_comb begin
        tgt_ready = (state_q == IDLE) && res;
    end

    assign accept = (state_q == IDLE) && tgt_valid;

    always_comb begin
        diff  = shadow_q ^ tgt;
        exc_j = '0;
        exc_k = '0;
        if (DC_POLICY != 0) begin
            exc_j = diff;
            exc_k = diff;
        end else begin
            exc_j = diff & tgt;
            exc_k = diff & shadow_q;
        end
    end

    always_comb begin
        j_d      = '0;
        k_d      = '0;
        tgt_d    = tgt_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        if (accept) begin
            tgt_d = tgt;
            j_d   = exc_j;
            k_d   = exc_k;
        end
        // Shadow always resyncs to the real bank, match or not.
        if (state_q == CHECK) begin
            shadow_d = q_fb;
            if (q_fb == tgt_q) begin
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            j_q      <= '0;
            k_q      <= '0;
            tgt_q    <= '0;
            shadow_q <= RESET_VAL;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            j_q      <= j_d;
            k_q      <= k_d;
            tgt_q    <= tgt_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule
